// File: rtl/usr_pkg.sv
// Shared mode encodings and mode-classification helpers for the universal
// shift register.
package usr_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    ASR  = 3'b110,
    CLR  = 3'b111
  } usr_mode_e;

  // Modes that restart the shift count: a fresh value is in the register.
  function automatic logic mode_clears_cnt(usr_mode_e mode);
    logic res;
    case (mode)
      LOAD, CLR: res = 1'b1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic mode_counts(usr_mode_e mode);
    logic res;
    case (mode)
      SHR, SHL, ASR: res = 1'b1;
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usr_param_if.sv
// Control, data and status bundle of the universal shift register.
interface usr_param_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);

  logic             en;
  logic [2:0]       sel;
  logic             MSB_in;
  logic             LSB_in;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] A;
  logic             MSB_out;
  logic             LSB_out;
  logic [CW-1:0]    cnt;
  logic             drained;

  modport master (
    output en, sel, MSB_in, LSB_in, I,
    input  A, MSB_out, LSB_out, cnt, drained
  );

  modport slave (
    input  en, sel, MSB_in, LSB_in, I,
    output A, MSB_out, LSB_out, cnt, drained
  );

endinterface

// File: rtl/usr_shift_cnt.sv
// Saturating count of single-bit shifts since the last load/clear, with a
// registered flag marking that a full register width has been shifted out.
module usr_shift_cnt #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          drained
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          drained_q;
  logic          drained_d;

  // Next count; drained is derived from the next count so both flip together.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = cnt_q;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != FULL)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    drained_d = (cnt_d == FULL);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
    end
  end

  assign cnt     = cnt_q;
  assign drained = drained_q;

endmodule

// File: rtl/usr_param.sv
// Parameterised universal shift register: hold, shift, rotate, arithmetic
// shift, parallel load and clear, with a saturating shift counter.
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  usr_param_if.slave  bus
);

  usr_mode_e        mode_s;
  logic             clr_s;
  logic             inc_s;
  logic [WIDTH-1:0] a_q;

  assign mode_s = usr_mode_e'(bus.sel);
  assign clr_s  = mode_clears_cnt(mode_s);
  assign inc_s  = mode_counts(mode_s);

  // Data path: serial inputs are only looked at in their own shift mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
    end else if (bus.en) begin
      case (mode_s)
        HOLD:    a_q <= a_q;
        SHR:     a_q <= {bus.MSB_in, a_q[WIDTH-1:1]};
        SHL:     a_q <= {a_q[WIDTH-2:0], bus.LSB_in};
        LOAD:    a_q <= bus.I;
        ROR:     a_q <= {a_q[0], a_q[WIDTH-1:1]};
        ROL:     a_q <= {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        ASR:     a_q <= {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        CLR:     a_q <= '0;
        default: a_q <= a_q;
      endcase
    end else begin
      a_q <= a_q;
    end
  end

  assign bus.A       = a_q;
  assign bus.MSB_out = a_q[WIDTH-1];
  assign bus.LSB_out = a_q[0];

  usr_shift_cnt #(
    .WIDTH (WIDTH)
  ) u_shift_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (bus.en),
    .clr     (clr_s),
    .inc     (inc_s),
    .cnt     (bus.cnt),
    .drained (bus.drained)
  );

endmodule

// File: tb/tb_usr_param.sv
// Self-checking bench for usr_param at WIDTH 8, 16 and 2: per-scenario
// tasks with inline checks plus a scoreboard compared every clock edge.
module tb_usr_param;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  usr_param_if #(.WIDTH(8))  if8 ();
  usr_param_if #(.WIDTH(16)) if16 ();
  usr_param_if #(.WIDTH(2))  if2 ();

  usr_param #(.WIDTH(8))  u8  (.clk(clk), .rstn(rstn), .bus(if8));
  usr_param #(.WIDTH(16)) u16 (.clk(clk), .rstn(rstn), .bus(if16));
  usr_param #(.WIDTH(2))  u2  (.clk(clk), .rstn(rstn), .bus(if2));

  int checks   = 0;
  int failures = 0;

  int          w     [3] = '{8, 16, 2};
  logic [63:0] m_a   [3];
  int          m_cnt [3];

  typedef struct {
    int          d;
    logic [63:0] a;
    int          c;
    string       nm;
  } exp_t;
  exp_t sb[$];

  function automatic logic [63:0] mask_of(int wd);
    return (64'd1 << wd) - 64'd1;
  endfunction

  function automatic logic [63:0] model_a(int wd, logic [63:0] a, logic [2:0] s,
                                          logic mi, logic li, logic [63:0] iv);
    logic [63:0] top_bit;
    logic [63:0] r;
    top_bit = {63'd0, a[wd-1]} << (wd - 1);
    case (s)
      3'd0:    r = a;
      3'd1:    r = (a >> 1) | ({63'd0, mi} << (wd - 1));
      3'd2:    r = ((a << 1) | {63'd0, li}) & mask_of(wd);
      3'd3:    r = iv & mask_of(wd);
      3'd4:    r = (a >> 1) | ({63'd0, a[0]} << (wd - 1));
      3'd5:    r = ((a << 1) | {63'd0, a[wd-1]}) & mask_of(wd);
      3'd6:    r = (a >> 1) | top_bit;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic void read_dut(input int d, output logic [63:0] a, output int c,
                                   output logic dr, output logic mo, output logic lo);
    case (d)
      0: begin a = {56'd0, if8.A}; c = int'(if8.cnt); dr = if8.drained;
               mo = if8.MSB_out; lo = if8.LSB_out; end
      1: begin a = {48'd0, if16.A}; c = int'(if16.cnt); dr = if16.drained;
               mo = if16.MSB_out; lo = if16.LSB_out; end
      default: begin a = {62'd0, if2.A}; c = int'(if2.cnt); dr = if2.drained;
               mo = if2.MSB_out; lo = if2.LSB_out; end
    endcase
  endfunction

  task automatic drive_in(int d, logic e, logic [2:0] s, logic mi, logic li, logic [63:0] iv);
    if8.en = 1'b0; if16.en = 1'b0; if2.en = 1'b0;
    case (d)
      0: begin if8.en = e; if8.sel = s; if8.MSB_in = mi; if8.LSB_in = li; if8.I = iv[7:0]; end
      1: begin if16.en = e; if16.sel = s; if16.MSB_in = mi; if16.LSB_in = li; if16.I = iv[15:0]; end
      default: begin if2.en = e; if2.sel = s; if2.MSB_in = mi; if2.LSB_in = li; if2.I = iv[1:0]; end
    endcase
  endtask

  // One clocked operation on DUT d; the expected result goes to the scoreboard.
  task automatic op(int d, logic e, logic [2:0] s, logic mi, logic li, logic [63:0] iv, string nm);
    @(negedge clk);
    drive_in(d, e, s, mi, li, iv);
    if (e) begin
      m_a[d] = model_a(w[d], m_a[d], s, mi, li, iv);
      if (s == 3'd3 || s == 3'd7) m_cnt[d] = 0;
      else if ((s == 3'd1 || s == 3'd2 || s == 3'd6) && m_cnt[d] < w[d]) m_cnt[d]++;
    end
    sb.push_back('{d, m_a[d], m_cnt[d], nm});
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: pops one expectation per edge and compares all outputs.
  always @(posedge clk) begin : mon
    exp_t        e;
    logic [63:0] a;
    int          c;
    logic        dr, mo, lo;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      read_dut(e.d, a, c, dr, mo, lo);
      checks += 5;
      if (a !== e.a) begin
        failures++;
        $display("FAIL sb_A %s w=%0d got=%h exp=%h", e.nm, w[e.d], a, e.a);
      end
      if (c != e.c) begin
        failures++;
        $display("FAIL sb_cnt %s w=%0d got=%0d exp=%0d", e.nm, w[e.d], c, e.c);
      end
      if (dr !== (e.c == w[e.d])) begin
        failures++;
        $display("FAIL sb_drained %s w=%0d got=%b exp=%b", e.nm, w[e.d], dr, (e.c == w[e.d]));
      end
      if (mo !== e.a[w[e.d]-1]) begin
        failures++;
        $display("FAIL sb_MSB_out %s w=%0d got=%b exp=%b", e.nm, w[e.d], mo, e.a[w[e.d]-1]);
      end
      if (lo !== e.a[0]) begin
        failures++;
        $display("FAIL sb_LSB_out %s w=%0d got=%b exp=%b", e.nm, w[e.d], lo, e.a[0]);
      end
    end
  end

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      m_a[d]   = 64'd0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic test_reset();
    logic [63:0] a; int c; logic dr, mo, lo;
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) drive_in(d, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0);
    if8.sel = 3'd3; if16.sel = 3'd3; if2.sel = 3'd3;
    if8.en = 1'b1; if16.en = 1'b1; if2.en = 1'b1;
    if8.I = 8'hFF; if16.I = 16'hFFFF; if2.I = 2'h3;
    reset_model();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      read_dut(d, a, c, dr, mo, lo);
      checks++;
      if (a !== 64'd0 || c != 0 || dr !== 1'b0) begin
        failures++;
        $display("FAIL reset w=%0d got A=%h cnt=%0d drained=%b exp A=0 cnt=0 drained=0", w[d], a, c, dr);
      end
    end
    for (int d = 0; d < 3; d++) drive_in(d, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0);
    rstn = 1'b1;
  endtask

  task automatic test_basic(int d);
    logic [63:0] exp_shr [3] = '{64'hD5, 64'h8055, 64'h3};
    logic [63:0] exp_shl [3] = '{64'h55, 64'h155, 64'h1};
    logic [63:0] a; int c; logic dr, mo, lo;
    op(d, 1'b1, LOAD, 1'b0, 1'b0, 64'hAA, "ld_aa");
    op(d, 1'b1, SHR, 1'b1, 1'b1, 64'h0, "shr");
    read_dut(d, a, c, dr, mo, lo);
    checks++;
    if (a !== exp_shr[d] || c != 1) begin
      failures++;
      $display("FAIL basic_shr w=%0d got A=%h cnt=%0d exp A=%h cnt=1", w[d], a, c, exp_shr[d]);
    end
    op(d, 1'b1, LOAD, 1'b0, 1'b0, 64'hAA, "ld_aa2");
    op(d, 1'b1, SHL, 1'b0, 1'b1, 64'h0, "shl");
    read_dut(d, a, c, dr, mo, lo);
    checks++;
    if (a !== exp_shl[d] || c != 1) begin
      failures++;
      $display("FAIL basic_shl w=%0d got A=%h cnt=%0d exp A=%h cnt=1", w[d], a, c, exp_shl[d]);
    end
  endtask

  task automatic test_rotate();
    logic [63:0] a; int c; logic dr, mo, lo;
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'hF0, "ld_f0");
    op(0, 1'b1, ROR, 1'b1, 1'b1, 64'h0, "ror");
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'h78 || c != 0) begin
      failures++;
      $display("FAIL ror got A=%h cnt=%0d exp A=78 cnt=0", a, c);
    end
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'h81, "ld_81");
    op(0, 1'b1, ROL, 1'b0, 1'b0, 64'h0, "rol");
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'h03) begin
      failures++;
      $display("FAIL rol got A=%h exp A=03", a);
    end
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'h80, "ld_80");
    op(0, 1'b1, ASR, 1'b0, 1'b0, 64'h0, "asr");
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'hC0 || c != 1) begin
      failures++;
      $display("FAIL asr got A=%h cnt=%0d exp A=c0 cnt=1", a, c);
    end
  endtask

  task automatic test_drain(int d);
    logic [63:0] a; int c; logic dr, mo, lo;
    op(d, 1'b1, LOAD, 1'b0, 1'b0, 64'hF0, "ld_f0");
    for (int i = 0; i < w[d]; i++) begin
      op(d, 1'b1, SHL, 1'b0, 1'b0, 64'h0, "drain_shl");
      if (i == w[d] - 2) begin
        read_dut(d, a, c, dr, mo, lo);
        checks++;
        if (c != w[d] - 1 || dr !== 1'b0) begin
          failures++;
          $display("FAIL drain_early w=%0d got cnt=%0d drained=%b exp cnt=%0d drained=0", w[d], c, dr, w[d] - 1);
        end
      end
    end
    read_dut(d, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'd0 || c != w[d] || dr !== 1'b1) begin
      failures++;
      $display("FAIL drain_full w=%0d got A=%h cnt=%0d drained=%b exp A=0 cnt=%0d drained=1", w[d], a, c, dr, w[d]);
    end
    op(d, 1'b1, SHL, 1'b0, 1'b1, 64'h0, "sat_shl");
    read_dut(d, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'd1 || c != w[d] || dr !== 1'b1) begin
      failures++;
      $display("FAIL drain_sat w=%0d got A=%h cnt=%0d drained=%b exp A=1 cnt=%0d drained=1", w[d], a, c, dr, w[d]);
    end
    op(d, 1'b1, LOAD, 1'b0, 1'b0, 64'h1, "reload");
    read_dut(d, a, c, dr, mo, lo);
    checks++;
    if (c != 0 || dr !== 1'b0) begin
      failures++;
      $display("FAIL drain_reload w=%0d got cnt=%0d drained=%b exp cnt=0 drained=0", w[d], c, dr);
    end
  endtask

  task automatic test_hold();
    logic [63:0] a; int c; logic dr, mo, lo;
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'h1E, "ld_1e");
    op(0, 1'b1, SHL, 1'b1, 1'b0, 64'h0, "shl_3c");
    for (int i = 0; i < 8; i++)
      op(0, 1'b0, 3'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         64'($urandom_range(0, 255)), "hold_en0");
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'h3C || c != 1 || dr !== 1'b0) begin
      failures++;
      $display("FAIL hold got A=%h cnt=%0d drained=%b exp A=3c cnt=1 drained=0", a, c, dr);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] a; int c; logic dr, mo, lo;
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'hFF, "ld_ff");
    for (int i = 0; i < 3; i++) op(0, 1'b1, SHR, 1'b0, 1'b0, 64'h0, "pre_rst_shr");
    #1;
    rstn = 1'b0;
    #1;
    reset_model();
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'd0 || c != 0 || dr !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got A=%h cnt=%0d drained=%b exp A=0 cnt=0 drained=0", a, c, dr);
    end
    @(negedge clk);
    drive_in(0, 1'b1, LOAD, 1'b0, 1'b0, 64'h77);
    @(posedge clk);
    #2;
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'd0 || c != 0) begin
      failures++;
      $display("FAIL rst_dominates got A=%h cnt=%0d exp A=0 cnt=0", a, c);
    end
    @(negedge clk);
    drive_in(0, 1'b0, HOLD, 1'b0, 1'b0, 64'h0);
    rstn = 1'b1;
    op(0, 1'b1, LOAD, 1'b0, 1'b0, 64'h5A, "ld_5a");
    read_dut(0, a, c, dr, mo, lo);
    checks++;
    if (a !== 64'h5A || c != 0) begin
      failures++;
      $display("FAIL post_rst_load got A=%h cnt=%0d exp A=5a cnt=0", a, c);
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 40; n++)
        op(d, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, "rand");
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d exp pending=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 3; d++) test_basic(d);
    test_rotate();
    for (int d = 0; d < 3; d++) test_drain(d);
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
